// File: rtl/udp_rx_pkg.sv
// Shared types for the UDP receive buffer manager: FSM states, the descriptor
// record handed to the MCU, and the lowest-free-slot search.
package udp_rx_pkg;

   // Default geometry: 4 slots of 512 32-bit words each.
   localparam int RX_NBUF_LOG2 = 2;
   localparam int RX_SLOT_W    = 9;
   localparam int RX_NBUF      = 2 ** RX_NBUF_LOG2;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DROP
   } rxbuf_state_t;

   // One completed packet: where it lives, how many words were stored,
   // whether the tail was cut off, and the receiver status word.
   typedef struct packed {
      logic [RX_NBUF_LOG2-1:0] slot;
      logic [RX_SLOT_W:0]      len;
      logic                    ovf;
      logic [31:0]             stat;
   } rx_desc_t;

   typedef struct packed {
      logic                    found;
      logic [RX_NBUF_LOG2-1:0] idx;
   } free_sel_t;

   // Scan from the top down so the last hit, and therefore the result,
   // is the lowest-numbered free slot.
   function automatic free_sel_t lowest_free(input logic [RX_NBUF-1:0] busy);
      free_sel_t sel;
      sel = '0;
      for (int i = RX_NBUF - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            sel.found = 1'b1;
            sel.idx   = i[RX_NBUF_LOG2-1:0];
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/udp_desc_fifo.sv
// Show-ahead descriptor FIFO: the head entry is visible on 'head' whenever
// 'valid' is high, and a pop simply advances to the next entry.
module udp_desc_fifo
   import udp_rx_pkg::*;
#(
   parameter int DEPTH_LOG2 = RX_NBUF_LOG2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  rx_desc_t            pushData,
   input  logic                pop,
   output logic                valid,
   output rx_desc_t            head,
   output logic [DEPTH_LOG2:0] count
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;

   rx_desc_t              store [DEPTH];
   logic [DEPTH_LOG2-1:0] wrPtr;
   logic [DEPTH_LOG2-1:0] rdPtr;
   logic                  full;
   logic                  doPush;
   logic                  doPop;

   // The count only reaches DEPTH when every entry is used, so its top bit
   // alone says "full". A pop on an empty FIFO is dropped here, and a push
   // into a full FIFO is only taken if a pop frees a place in the same cycle.
   assign valid  = (count != '0);
   assign full   = count[DEPTH_LOG2];
   assign doPop  = pop && valid;
   assign doPush = push && (!full || doPop);
   assign head   = store[rdPtr];

   // Entry storage has no reset; entries only become visible after a push
   // writes them, so their power-up contents never reach the outputs.
   always_ff @(posedge clk) begin
      if (doPush) begin
         store[wrPtr] <= pushData;
      end
   end

   // Pointer and occupancy bookkeeping. A push and a pop together leave the
   // count unchanged while both pointers still move.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (doPop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/udp_rx_buf_ctrl.sv
// Packet RAM buffer manager for the UDP receiver. Each packet is written into
// its own fixed-size slot, and a descriptor is queued for the MCU when the
// packet ends; the slot stays owned until the MCU releases it.
// Optional statistics counters are built when UDP_RX_BUF_STATS_EN is defined;
// otherwise pkt_cnt and drop_cnt read as zero.
// The descriptor record uses the package geometry, so NBUF_LOG2 and SLOT_W
// are expected to stay at the package values.
module udp_rx_buf_ctrl
   import udp_rx_pkg::*;
#(
   parameter int NBUF_LOG2 = RX_NBUF_LOG2,
   parameter int SLOT_W    = RX_SLOT_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wren_mem,
   input  logic [31:0]             data_to_mem,
   input  logic                    desc_wr,
   input  logic [31:0]             stat_err,
   output logic                    mem_we,
   output logic [NBUF_LOG2+SLOT_W-1:0] mem_addr,
   output logic [31:0]             mem_wdata,
   output logic                    desc_valid,
   output logic [NBUF_LOG2-1:0]    desc_slot,
   output logic [SLOT_W:0]         desc_len,
   output logic                    desc_ovf,
   output logic [31:0]             desc_stat,
   input  logic                    desc_pop,
   input  logic                    buf_release,
   input  logic [NBUF_LOG2-1:0]    release_slot,
   output logic                    rel_err,
   output logic                    irq,
   output logic [15:0]             pkt_cnt,
   output logic [15:0]             drop_cnt
);

   localparam int NBUF = 2 ** NBUF_LOG2;
   localparam int AW   = NBUF_LOG2 + SLOT_W;
   localparam logic [SLOT_W:0] SLOT_WORDS = {1'b1, {SLOT_W{1'b0}}};
   localparam logic [SLOT_W:0] LEN_ONE    = {{SLOT_W{1'b0}}, 1'b1};

   rxbuf_state_t          state;
   rxbuf_state_t          stateNext;
   logic [NBUF-1:0]       busyMap;
   logic [NBUF-1:0]       busyNext;
   logic [NBUF-1:0]       allocMask;
   logic [NBUF-1:0]       relMask;
   logic [NBUF_LOG2-1:0]  curSlot;
   logic [NBUF_LOG2-1:0]  curSlotNext;
   logic [SLOT_W:0]       wrOffset;
   logic [SLOT_W:0]       wrOffsetNext;
   logic [SLOT_W:0]       lenNow;
   logic                  ovfFlag;
   logic                  ovfFlagNext;
   logic                  ovfNow;
   logic                  memWeNext;
   logic [AW-1:0]         memAddrNext;
   logic [31:0]           memWdataNext;
   logic                  relBad;
   logic                  relErrNext;
   logic                  pushReq;
   rx_desc_t              pushDesc;
   logic                  pktInc;
   logic                  dropInc;
   free_sel_t             freeSel;

   logic                  fifoValid;
   rx_desc_t              fifoHead;
   logic [NBUF_LOG2:0]    unusedDescCount;

   udp_desc_fifo #(
      .DEPTH_LOG2(NBUF_LOG2)
   ) descFifo (
      .clk     (clk),
      .rst     (rst),
      .push    (pushReq),
      .pushData(pushDesc),
      .pop     (desc_pop),
      .valid   (fifoValid),
      .head    (fifoHead),
      .count   (unusedDescCount)
   );

   // Head fields are forced to zero while the FIFO is empty so the MCU never
   // sees a stale descriptor, and so everything reads zero out of reset.
   assign desc_valid = fifoValid;
   assign desc_slot  = fifoValid ? fifoHead.slot : '0;
   assign desc_len   = fifoValid ? fifoHead.len  : '0;
   assign desc_ovf   = fifoValid ? fifoHead.ovf  : 1'b0;
   assign desc_stat  = fifoValid ? fifoHead.stat : '0;

   // Packet FSM, slot allocation and release handling. Allocation searches
   // the bitmap as it stood at the start of the cycle, so a slot released in
   // the same cycle only becomes allocatable one cycle later. The word count
   // saturates at a full slot; extra words only raise the overflow flag.
   always_comb begin
      stateNext    = state;
      curSlotNext  = curSlot;
      wrOffsetNext = wrOffset;
      ovfFlagNext  = ovfFlag;
      lenNow       = wrOffset;
      ovfNow       = ovfFlag;
      memWeNext    = 1'b0;
      memAddrNext  = '0;
      memWdataNext = data_to_mem;
      allocMask    = '0;
      relMask      = '0;
      pushReq      = 1'b0;
      pushDesc     = '0;
      pktInc       = 1'b0;
      dropInc      = 1'b0;
      freeSel      = lowest_free(busyMap);

      case (state)
         IDLE: begin
            if (wren_mem) begin
               if (freeSel.found) begin
                  allocMask[freeSel.idx] = 1'b1;
                  curSlotNext            = freeSel.idx;
                  wrOffsetNext           = LEN_ONE;
                  ovfFlagNext            = 1'b0;
                  memWeNext              = 1'b1;
                  memAddrNext            = {freeSel.idx, {SLOT_W{1'b0}}};
                  stateNext              = FILL;
               end else begin
                  dropInc   = 1'b1;
                  stateNext = DROP;
               end
            end
         end
         FILL: begin
            if (wren_mem) begin
               if (wrOffset == SLOT_WORDS) begin
                  ovfNow = 1'b1;
               end else begin
                  memWeNext   = 1'b1;
                  memAddrNext = {curSlot, wrOffset[SLOT_W-1:0]};
                  lenNow      = wrOffset + LEN_ONE;
               end
            end
            wrOffsetNext = lenNow;
            ovfFlagNext  = ovfNow;
            if (desc_wr) begin
               pushReq       = 1'b1;
               pushDesc.slot = curSlot;
               pushDesc.len  = lenNow;
               pushDesc.ovf  = ovfNow;
               pushDesc.stat = stat_err;
               pktInc        = 1'b1;
               stateNext     = IDLE;
            end
         end
         DROP: begin
            if (desc_wr) begin
               stateNext = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase

      relBad     = !busyMap[release_slot] ||
                   ((state == FILL) && (release_slot == curSlot));
      relErrNext = buf_release && relBad;
      if (buf_release && !relBad) begin
         relMask[release_slot] = 1'b1;
      end
      busyNext = (busyMap & ~relMask) | allocMask;
   end

   // State, bitmap and the registered RAM write port. The RAM write trails
   // the receiver strobe by one cycle; irq is a registered copy of desc_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         busyMap   <= '0;
         curSlot   <= '0;
         wrOffset  <= '0;
         ovfFlag   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rel_err   <= 1'b0;
         irq       <= 1'b0;
      end else begin
         state     <= stateNext;
         busyMap   <= busyNext;
         curSlot   <= curSlotNext;
         wrOffset  <= wrOffsetNext;
         ovfFlag   <= ovfFlagNext;
         mem_we    <= memWeNext;
         mem_addr  <= memAddrNext;
         mem_wdata <= memWdataNext;
         rel_err   <= relErrNext;
         irq       <= fifoValid;
      end
   end

`ifdef UDP_RX_BUF_STATS_EN
   logic [15:0] pktCnt;
   logic [15:0] dropCnt;

   // Accepted and dropped packet counters; both simply wrap past 16'hFFFF.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pktCnt  <= '0;
         dropCnt <= '0;
      end else begin
         if (pktInc) begin
            pktCnt <= pktCnt + 16'd1;
         end
         if (dropInc) begin
            dropCnt <= dropCnt + 16'd1;
         end
      end
   end

   assign pkt_cnt  = pktCnt;
   assign drop_cnt = dropCnt;
`else
   logic unusedStats;

   assign unusedStats = pktInc ^ dropInc;
   assign pkt_cnt     = 16'h0000;
   assign drop_cnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_udp_rx_buf_ctrl.sv
// Directed self-checking bench for udp_rx_buf_ctrl.
module tb_udp_rx_buf_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        wren_mem;
   logic [31:0] data_to_mem;
   logic        desc_wr;
   logic [31:0] stat_err;
   logic        mem_we;
   logic [10:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        desc_valid;
   logic [1:0]  desc_slot;
   logic [9:0]  desc_len;
   logic        desc_ovf;
   logic [31:0] desc_stat;
   logic        desc_pop;
   logic        buf_release;
   logic [1:0]  release_slot;
   logic        rel_err;
   logic        irq;
   logic [15:0] pkt_cnt;
   logic [15:0] drop_cnt;

   int          checkCount = 0;
   int          failCount  = 0;
   int          writeCount = 0;
   logic [10:0] lastAddr   = '0;
   logic [31:0] lastData   = '0;

   udp_rx_buf_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .wren_mem    (wren_mem),
      .data_to_mem (data_to_mem),
      .desc_wr     (desc_wr),
      .stat_err    (stat_err),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .desc_valid  (desc_valid),
      .desc_slot   (desc_slot),
      .desc_len    (desc_len),
      .desc_ovf    (desc_ovf),
      .desc_stat   (desc_stat),
      .desc_pop    (desc_pop),
      .buf_release (buf_release),
      .release_slot(release_slot),
      .rel_err     (rel_err),
      .irq         (irq),
      .pkt_cnt     (pkt_cnt),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk = ~clk;

   // Tally RAM writes on the falling edge, away from the registered update.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         writeCount = writeCount + 1;
         lastAddr   = mem_addr;
         lastData   = mem_wdata;
      end
   end

   function automatic logic [31:0] statExp(input int v);
`ifdef UDP_RX_BUF_STATS_EN
      return 32'(v);
`else
      return 32'(v - v);
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, then land 1 time unit after the clock edge.
   task automatic applyStimulus(input logic wr, input logic [31:0] d, input logic dw,
                                input logic [31:0] st, input logic pp, input logic rl,
                                input logic [1:0] rs);
      wren_mem     = wr;
      data_to_mem  = d;
      desc_wr      = dw;
      stat_err     = st;
      desc_pop     = pp;
      buf_release  = rl;
      release_slot = rs;
      @(posedge clk);
      #1;
      wren_mem    = 1'b0;
      desc_wr     = 1'b0;
      desc_pop    = 1'b0;
      buf_release = 1'b0;
   endtask

   task automatic sendWords(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b1, base + 32'(i), 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
      end
   endtask

   task automatic endPacket(input logic [31:0] st, input logic pp);
      applyStimulus(1'b0, 32'h0, 1'b1, st, pp, 1'b0, 2'd0);
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
   endtask

   task automatic popDesc();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 2'd0);
   endtask

   task automatic releaseSlot(input logic [1:0] s);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, s);
   endtask

   initial begin
      rst = 1'b1;
      wren_mem = 1'b0; data_to_mem = '0; desc_wr = 1'b0; stat_err = '0;
      desc_pop = 1'b0; buf_release = 1'b0; release_slot = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst mem_we", 32'(mem_we), 32'd0);
      checkOutput("rst mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("rst desc_valid", 32'(desc_valid), 32'd0);
      checkOutput("rst desc_len", 32'(desc_len), 32'd0);
      checkOutput("rst irq", 32'(irq), 32'd0);
      checkOutput("rst rel_err", 32'(rel_err), 32'd0);
      checkOutput("rst pkt_cnt", 32'(pkt_cnt), 32'd0);
      checkOutput("rst drop_cnt", 32'(drop_cnt), 32'd0);
      rst = 1'b0;
      idleCycle();

      // 1) 3-word packet into an empty controller
      applyStimulus(1'b1, 32'hA000_0000, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
      checkOutput("t1 w0 we", 32'(mem_we), 32'd1);
      checkOutput("t1 w0 addr", 32'(mem_addr), 32'd0);
      checkOutput("t1 w0 data", mem_wdata, 32'hA000_0000);
      applyStimulus(1'b1, 32'hA000_0001, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
      checkOutput("t1 w1 addr", 32'(mem_addr), 32'd1);
      applyStimulus(1'b1, 32'hA000_0002, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
      checkOutput("t1 w2 addr", 32'(mem_addr), 32'd2);
      checkOutput("t1 w2 data", mem_wdata, 32'hA000_0002);
      endPacket(32'hCAFE_0001, 1'b0);
      checkOutput("t1 desc_valid", 32'(desc_valid), 32'd1);
      checkOutput("t1 desc_slot", 32'(desc_slot), 32'd0);
      checkOutput("t1 desc_len", 32'(desc_len), 32'd3);
      checkOutput("t1 desc_ovf", 32'(desc_ovf), 32'd0);
      checkOutput("t1 desc_stat", desc_stat, 32'hCAFE_0001);
      checkOutput("t1 irq lag", 32'(irq), 32'd0);
      checkOutput("t1 we idle", 32'(mem_we), 32'd0);
      idleCycle();
      checkOutput("t1 irq", 32'(irq), 32'd1);
      checkOutput("t1 pkt_cnt", 32'(pkt_cnt), statExp(1));
      popDesc();
      checkOutput("t1 pop empty", 32'(desc_valid), 32'd0);
      releaseSlot(2'd0);
      checkOutput("t1 release ok", 32'(rel_err), 32'd0);

      // 2) four 8-word packets fill every slot, the fifth is dropped
      writeCount = 0;
      for (int p = 0; p < 4; p++) begin
         sendWords(8, 32'h100 * 32'(p + 1));
         endPacket(32'h200 + 32'(p), 1'b0);
      end
      checkOutput("t2 writes", 32'(writeCount), 32'd32);
      checkOutput("t2 last addr", 32'(lastAddr), 32'd1543);
      checkOutput("t2 last data", lastData, 32'h407);
      checkOutput("t2 head slot", 32'(desc_slot), 32'd0);
      checkOutput("t2 head len", 32'(desc_len), 32'd8);
      checkOutput("t2 head stat", desc_stat, 32'h200);
      sendWords(8, 32'h500);
      endPacket(32'h204, 1'b0);
      checkOutput("t2 drop writes", 32'(writeCount), 32'd32);
      checkOutput("t2 drop_cnt", 32'(drop_cnt), statExp(1));
      checkOutput("t2 pkt_cnt", 32'(pkt_cnt), statExp(5));
      popDesc();
      checkOutput("t2 pop1 slot", 32'(desc_slot), 32'd1);
      popDesc();
      checkOutput("t2 pop2 slot", 32'(desc_slot), 32'd2);
      popDesc();
      checkOutput("t2 pop3 slot", 32'(desc_slot), 32'd3);
      checkOutput("t2 pop3 stat", desc_stat, 32'h203);
      popDesc();
      checkOutput("t2 no fifth desc", 32'(desc_valid), 32'd0);

      // 4) release slot 2 alongside a new packet start while all slots busy
      applyStimulus(1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 1'b1, 2'd2);
      checkOutput("t4 drop we", 32'(mem_we), 32'd0);
      checkOutput("t4 rel_err", 32'(rel_err), 32'd0);
      sendWords(1, 32'h601);
      checkOutput("t4 drop we2", 32'(mem_we), 32'd0);
      endPacket(32'h300, 1'b0);
      checkOutput("t4 no desc", 32'(desc_valid), 32'd0);
      checkOutput("t4 drop_cnt", 32'(drop_cnt), statExp(2));
      writeCount = 0;
      sendWords(1, 32'h700);
      checkOutput("t4 slot2 addr", 32'(mem_addr), 32'd1024);
      sendWords(1, 32'h701);
      endPacket(32'h301, 1'b0);
      checkOutput("t4 writes", 32'(writeCount), 32'd2);
      checkOutput("t4 desc slot", 32'(desc_slot), 32'd2);
      checkOutput("t4 desc len", 32'(desc_len), 32'd2);

      // 5) push with coincident pop at count 1, then release errors
      releaseSlot(2'd0);
      sendWords(1, 32'h800);
      checkOutput("t5 addr", 32'(mem_addr), 32'd0);
      endPacket(32'h555, 1'b1);
      checkOutput("t5 push+pop valid", 32'(desc_valid), 32'd1);
      checkOutput("t5 head slot", 32'(desc_slot), 32'd0);
      checkOutput("t5 head len", 32'(desc_len), 32'd1);
      checkOutput("t5 head stat", desc_stat, 32'h555);
      popDesc();
      checkOutput("t5 count was 1", 32'(desc_valid), 32'd0);
      releaseSlot(2'd0);
      checkOutput("t5 rel ok", 32'(rel_err), 32'd0);
      releaseSlot(2'd0);
      checkOutput("t5 rel free err", 32'(rel_err), 32'd1);
      idleCycle();
      checkOutput("t5 rel_err pulse", 32'(rel_err), 32'd0);
      sendWords(1, 32'h900);
      checkOutput("t5 slot0 still free", 32'(mem_addr), 32'd0);
      applyStimulus(1'b1, 32'h901, 1'b0, 32'h0, 1'b0, 1'b1, 2'd0);
      checkOutput("t5 rel fill err", 32'(rel_err), 32'd1);
      checkOutput("t5 fill addr", 32'(mem_addr), 32'd1);
      endPacket(32'h666, 1'b0);
      checkOutput("t5 fill desc len", 32'(desc_len), 32'd2);
      checkOutput("t5 pkt_cnt", 32'(pkt_cnt), statExp(8));
      sendWords(1, 32'hA00);
      checkOutput("t5 slot0 kept busy", 32'(mem_we), 32'd0);
      endPacket(32'h667, 1'b0);
      checkOutput("t5 drop_cnt", 32'(drop_cnt), statExp(3));
      checkOutput("t5 head unchanged", desc_stat, 32'h666);
      popDesc();

      // 3) 514-word packet overflows a 512-word slot
      releaseSlot(2'd1);
      writeCount = 0;
      sendWords(514, 32'h1_0000);
      endPacket(32'h777, 1'b0);
      checkOutput("t3 writes", 32'(writeCount), 32'd512);
      checkOutput("t3 last addr", 32'(lastAddr), 32'd1023);
      checkOutput("t3 last data", lastData, 32'h1_01FF);
      checkOutput("t3 desc slot", 32'(desc_slot), 32'd1);
      checkOutput("t3 desc len", 32'(desc_len), 32'd512);
      checkOutput("t3 desc ovf", 32'(desc_ovf), 32'd1);
      checkOutput("t3 pkt_cnt", 32'(pkt_cnt), statExp(9));

      // 6) reset in the middle of a packet
      releaseSlot(2'd3);
      sendWords(1, 32'hB00);
      checkOutput("t6 slot3 addr", 32'(mem_addr), 32'd1536);
      sendWords(1, 32'hB01);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("t6 rst mem_we", 32'(mem_we), 32'd0);
      checkOutput("t6 rst mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("t6 rst desc_valid", 32'(desc_valid), 32'd0);
      checkOutput("t6 rst irq", 32'(irq), 32'd0);
      checkOutput("t6 rst pkt_cnt", 32'(pkt_cnt), 32'd0);
      checkOutput("t6 rst drop_cnt", 32'(drop_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      popDesc();
      checkOutput("t6 pop empty", 32'(desc_valid), 32'd0);
      sendWords(1, 32'hC00);
      checkOutput("t6 new addr", 32'(mem_addr), 32'd0);
      sendWords(1, 32'hC01);
      endPacket(32'h888, 1'b0);
      checkOutput("t6 desc slot", 32'(desc_slot), 32'd0);
      checkOutput("t6 desc len", 32'(desc_len), 32'd2);
      checkOutput("t6 pkt_cnt", 32'(pkt_cnt), statExp(1));
      popDesc();
      checkOutput("t6 drained", 32'(desc_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
